// File: rtl/weight_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : weight_sampler_pkg
// Purpose : Shared constants and types for the weight_sampler acquisition
//           stage (output word width/limit, tare FSM state encoding).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package weight_sampler_pkg;

   // Width and ceiling of the weightInGrams word consumed by the converter
   localparam int WEIGHT_W   = 12;
   localparam int WEIGHT_MAX = 4095;

   // Tare capture FSM
   typedef enum logic [0:0] {
      TARE_IDLE  = 1'b0,
      TARE_ARMED = 1'b1
   } tare_state_e;

endpackage
`default_nettype wire

// File: rtl/weight_sampler_sample_averager.sv
`default_nettype none
// ============================================================================
// Module  : sample_averager
// Purpose : Accumulates windows of 2^AVG_LOG2 raw samples. The window sum is
//           presented combinationally alongside the last sample so that the
//           next stage registers it on the same edge the sample is accepted;
//           the accumulator restarts on that edge, so a sample arriving the
//           very next cycle opens the new window.
// Ports   : clk, rst_n           clock / async active-low reset
//           sampleIn, sampleValid raw ADC sample and its qualifier
//           sum, sumValid        completed window sum (valid with last sample)
// Rev     : 1.0  initial release
// ============================================================================
module sample_averager
   import weight_sampler_pkg::*;
#(
   parameter int RAW_W    = 16,
   parameter int AVG_LOG2 = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [RAW_W-1:0]          sampleIn,
   input  logic                      sampleValid,
   output logic [RAW_W+AVG_LOG2-1:0] sum,
   output logic                      sumValid
);

   localparam int SUM_W = RAW_W + AVG_LOG2;

   logic [SUM_W-1:0]    acc;
   logic [AVG_LOG2-1:0] cnt;
   logic                last_sample;

   // 2^AVG_LOG2 samples of all-ones fit exactly in SUM_W bits
   assign sum         = acc + {{AVG_LOG2{1'b0}}, sampleIn};
   assign last_sample = &cnt;
   assign sumValid    = sampleValid & last_sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (sampleValid) begin
         // Counter wraps to zero naturally after the last sample
         cnt <= cnt + 1'b1;
         if (last_sample) begin
            acc <= '0;
         end else begin
            acc <= sum;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/weight_sampler.sv
`default_nettype none
// ============================================================================
// Module  : weight_sampler
// Purpose : Load-cell acquisition stage ahead of the grams-to-kilograms
//           converter: window averaging, calibration scaling, tare
//           subtraction, 12-bit saturation, overload and stability flags.
//           Pipeline: window sum (comb) -> stage 1 scaled (reg) ->
//           stage 2 tared/saturated output (reg); last sample in cycle t
//           gives weightValid in cycle t+2.
// Ports   : clk, rst_n           clock / async active-low reset
//           sampleIn, sampleValid raw ADC sample and qualifier
//           tareReq              tare request (rising edge detected)
//           weightInGrams        tared, saturated weight
//           weightValid          one-cycle update strobe
//           overload             last window exceeded WEIGHT_MAX
//           tareBusy             tare capture pending
//           stable               reading stable
// Rev     : 1.0  initial release
// ============================================================================
module weight_sampler
   import weight_sampler_pkg::*;
#(
   parameter int RAW_W      = 16,
   parameter int AVG_LOG2   = 3,
   parameter int CAL_NUM    = 1,
   parameter int CAL_SHIFT  = 0,
   parameter int STABLE_TOL = 2,
   parameter int STABLE_CNT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [RAW_W-1:0]    sampleIn,
   input  logic                sampleValid,
   input  logic                tareReq,
   output logic [WEIGHT_W-1:0] weightInGrams,
   output logic                weightValid,
   output logic                overload,
   output logic                tareBusy,
   output logic                stable
);

   localparam int SUM_W    = RAW_W + AVG_LOG2;
   localparam int SCALED_W = RAW_W + 8;
   localparam int CNT_W    = $clog2(STABLE_CNT + 1);

   localparam logic [7:0]          CAL       = CAL_NUM[7:0];
   localparam logic [SCALED_W-1:0] SCALED_MX = SCALED_W'(WEIGHT_MAX);
   localparam logic [WEIGHT_W:0]   TOL       = (WEIGHT_W + 1)'(STABLE_TOL);
   localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(STABLE_CNT);

   // ------------------------------------------------------------------
   // Window accumulation
   // ------------------------------------------------------------------
   logic [SUM_W-1:0] sum;
   logic             sum_valid;

   sample_averager #(
      .RAW_W    (RAW_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_averager (
      .clk         (clk),
      .rst_n       (rst_n),
      .sampleIn    (sampleIn),
      .sampleValid (sampleValid),
      .sum         (sum),
      .sumValid    (sum_valid)
   );

   // ------------------------------------------------------------------
   // Stage 1: average and calibrate
   // ------------------------------------------------------------------
   logic [RAW_W-1:0]    avg;
   logic [AVG_LOG2-1:0] unused_sum_lsbs;  // truncated by the averaging shift
   logic [SCALED_W-1:0] product;
   logic [SCALED_W-1:0] scaled_next;
   logic [SCALED_W-1:0] s1_scaled;
   logic                s1_valid;

   assign avg             = sum[SUM_W-1:AVG_LOG2];
   assign unused_sum_lsbs = sum[AVG_LOG2-1:0];
   // RAW_W x 8-bit product always fits in SCALED_W bits
   assign product         = {8'd0, avg} * {{RAW_W{1'b0}}, CAL};
   assign scaled_next     = product >> CAL_SHIFT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_scaled <= '0;
      end else begin
         s1_valid <= sum_valid;
         if (sum_valid) begin
            s1_scaled <= scaled_next;
         end
      end
   end

   // ------------------------------------------------------------------
   // Tare request edge detect and capture FSM
   // ------------------------------------------------------------------
   tare_state_e state;
   logic        tare_req_d;
   logic        tare_rise;
   logic        capture;

   assign tare_rise = tareReq & ~tare_req_d;
   // Only a window reaching stage 1 after arming is captured; one already in
   // stage 1 on the arming edge passes through normally.
   assign capture   = (state == TARE_ARMED) & s1_valid;
   assign tareBusy  = (state == TARE_ARMED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= TARE_IDLE;
         tare_req_d <= 1'b0;
      end else begin
         tare_req_d <= tareReq;
         case (state)
            TARE_IDLE: begin
               if (tare_rise) begin
                  state <= TARE_ARMED;
               end
            end
            TARE_ARMED: begin
               // Extra request edges while armed are deliberately ignored
               if (s1_valid) begin
                  state <= TARE_IDLE;
               end
            end
            default: state <= TARE_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: tare subtraction, saturation, stability tracking
   // ------------------------------------------------------------------
   logic [SCALED_W-1:0]        tare;
   logic signed [SCALED_W:0]   diff;
   logic [WEIGHT_W-1:0]        sat_weight;
   logic                       sat_ovl;
   logic signed [WEIGHT_W:0]   delta;
   logic [WEIGHT_W:0]          delta_abs;
   logic                       within_tol;
   logic [CNT_W-1:0]           stable_cnt;

   assign diff = $signed({1'b0, s1_scaled}) - $signed({1'b0, tare});

   always_comb begin
      sat_weight = '0;
      sat_ovl    = 1'b0;
      if (diff[SCALED_W]) begin
         sat_weight = '0;
      end else if (diff[SCALED_W-1:0] > SCALED_MX) begin
         sat_weight = WEIGHT_W'(WEIGHT_MAX);
         sat_ovl    = 1'b1;
      end else begin
         sat_weight = diff[WEIGHT_W-1:0];
      end
   end

   // weightInGrams doubles as the previous-output register for stability
   assign delta      = $signed({1'b0, sat_weight}) - $signed({1'b0, weightInGrams});
   assign delta_abs  = delta[WEIGHT_W] ? 13'(-delta) : 13'(delta);
   assign within_tol = (delta_abs <= TOL);
   assign stable     = (stable_cnt == CNT_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tare          <= '0;
         weightInGrams <= '0;
         weightValid   <= 1'b0;
         overload      <= 1'b0;
         stable_cnt    <= '0;
      end else begin
         weightValid <= s1_valid;
         if (s1_valid) begin
            if (capture) begin
               // Tare window itself reads as zero and restarts stability
               tare          <= s1_scaled;
               weightInGrams <= '0;
               overload      <= 1'b0;
               stable_cnt    <= '0;
            end else begin
               weightInGrams <= sat_weight;
               overload      <= sat_ovl;
               if (!within_tol) begin
                  stable_cnt <= '0;
               end else if (stable_cnt != CNT_FULL) begin
                  stable_cnt <= stable_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_weight_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_weight_sampler
// Purpose : Self-checking bench for weight_sampler (AVG_LOG2=2, CAL 1/0,
//           STABLE_TOL=2, STABLE_CNT=4). Expected outputs are queued when
//           the last sample of a window is driven and compared when
//           weightValid appears, including the exact arrival cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_weight_sampler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sampleIn;
   logic        sampleValid;
   logic        tareReq;
   logic [11:0] weightInGrams;
   logic        weightValid;
   logic        overload;
   logic        tareBusy;
   logic        stable;

   weight_sampler #(
      .RAW_W      (16),
      .AVG_LOG2   (2),
      .CAL_NUM    (1),
      .CAL_SHIFT  (0),
      .STABLE_TOL (2),
      .STABLE_CNT (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sampleIn      (sampleIn),
      .sampleValid   (sampleValid),
      .tareReq       (tareReq),
      .weightInGrams (weightInGrams),
      .weightValid   (weightValid),
      .overload      (overload),
      .tareBusy      (tareBusy),
      .stable        (stable)
   );

   always #5 clk = ~clk;

   typedef struct {
      int w;
      int o;
      int s;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cycle    = 0;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   vld_cnt  = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input int obs, input int exp);
      chk_cnt++;
      if (obs == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && weightValid) begin
         vld_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("weight",   int'(weightInGrams), e.w);
            check("overload", int'(overload),      e.o);
            check("stable",   int'(stable),        e.s);
            check("latency",  cycle,               e.cyc);
         end
      end
   end

   // Four samples of one value; expectation queued with the last sample
   task automatic window(input int v, input int ew, input int eo, input int es);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sampleIn    = 16'(v);
         sampleValid = 1'b1;
         if (i == 3) sb.push_back('{ew, eo, es, cycle + 2});
      end
      @(negedge clk);
      sampleValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic tare_pulse();
      @(negedge clk);
      tareReq = 1'b1;
      @(negedge clk);
      tareReq = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int vbase;
      rst_n       = 1'b0;
      sampleIn    = '0;
      sampleValid = 1'b0;
      tareReq     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_weight",   int'(weightInGrams), 0);
      check("rst_valid",    int'(weightValid),   0);
      check("rst_overload", int'(overload),      0);
      check("rst_tarebusy", int'(tareBusy),      0);
      check("rst_stable",   int'(stable),        0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic, saturation, recovery
      window(1500, 1500, 0, 0); drain();
      window(5000, 4095, 1, 0); drain();
      window(100,  100,  0, 0); drain();
      // All-ones samples: accumulator must not wrap (clamps at ceiling)
      window(65535, 4095, 1, 0); drain();
      window(100,  100,  0, 0); drain();

      // Back-to-back windows, sampleValid high for 12 cycles
      vbase = vld_cnt;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         sampleIn    = 16'd200;
         sampleValid = 1'b1;
         if (i % 4 == 3) sb.push_back('{200, 0, 0, cycle + 2});
      end
      @(negedge clk);
      sampleValid = 1'b0;
      drain();
      check("b2b_pulses", vld_cnt - vbase, 3);

      // Tare
      window(1000, 1000, 0, 0); drain();
      window(1000, 1000, 0, 0); drain();
      tare_pulse();
      check("tare_busy_set", int'(tareBusy), 1);
      tare_pulse();                       // ignored while armed
      check("tare_busy_hold", int'(tareBusy), 1);
      window(1000, 0, 0, 0); drain();
      check("tare_busy_clr", int'(tareBusy), 0);
      window(1300, 300, 0, 0); drain();
      window(900,  0,   0, 0); drain();

      // Stability (tare = 1000)
      window(1500, 500, 0, 0); drain();
      window(1501, 501, 0, 0); drain();
      window(1499, 499, 0, 0); drain();
      window(1500, 500, 0, 0); drain();
      window(1502, 502, 0, 1); drain();
      window(1510, 510, 0, 0); drain();

      // Async reset while armed and mid-window
      tare_pulse();
      check("arm_before_rst", int'(tareBusy), 1);
      @(negedge clk); sampleIn = 16'd3000; sampleValid = 1'b1;
      @(negedge clk);
      @(negedge clk); sampleValid = 1'b0;
      check("weight_before_rst", int'(weightInGrams), 510);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_weight",   int'(weightInGrams), 0);
      check("arst_tarebusy", int'(tareBusy),      0);
      check("arst_overload", int'(overload),      0);
      check("arst_stable",   int'(stable),        0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      // Partial sum discarded and tare cleared
      window(700, 700, 0, 0); drain();
      check("post_rst_tarebusy", int'(tareBusy), 0);

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
